// File: rtl/bip_pkg.sv
// Shared BIP control definitions: widths, opcodes, mux select encodings,
// sequencer states and the decoded control word.
package bip_pkg;

  localparam int DATA_LENGTH   = 16;
  localparam int OPCODE_LENGTH = 5;
  localparam int ADDR_LENGTH   = DATA_LENGTH - OPCODE_LENGTH;

  localparam logic [OPCODE_LENGTH-1:0] OP_HLT  = 5'b00000;
  localparam logic [OPCODE_LENGTH-1:0] OP_STO  = 5'b00001;
  localparam logic [OPCODE_LENGTH-1:0] OP_LD   = 5'b00010;
  localparam logic [OPCODE_LENGTH-1:0] OP_LDI  = 5'b00011;
  localparam logic [OPCODE_LENGTH-1:0] OP_ADD  = 5'b00100;
  localparam logic [OPCODE_LENGTH-1:0] OP_ADDI = 5'b00101;
  localparam logic [OPCODE_LENGTH-1:0] OP_SUB  = 5'b00110;
  localparam logic [OPCODE_LENGTH-1:0] OP_SUBI = 5'b00111;

  typedef enum logic [1:0] {
    SELA_MEM = 2'b00,
    SELA_SIG = 2'b01,
    SELA_ALU = 2'b10
  } sel_a_t;

  typedef enum logic {
    MEMORY = 1'b0,
    SIGNAL = 1'b1
  } sel_b_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_EXEC  = 2'b10,
    ST_HALT  = 2'b11
  } state_t;

  typedef struct packed {
    sel_a_t sel_a;
    sel_b_t sel_b;
    logic   op;
    logic   wr_acc;
    logic   rd_ram;
    logic   wr_ram;
    logic   is_hlt;
    logic   is_illegal;
  } ctrl_t;

endpackage

// File: rtl/bip_control_unit_if.sv
// Program-memory and datapath-control bundle between the BIP sequencer
// (master) and the memories/datapath it drives (slave).
interface bip_control_unit_if;
  import bip_pkg::*;

  logic                   start;
  logic [DATA_LENGTH-1:0] instr;
  logic [ADDR_LENGTH-1:0] prog_addr;
  logic [ADDR_LENGTH-1:0] data_addr;
  logic [DATA_LENGTH-1:0] signal_ext;
  logic [1:0]             sel_a;
  logic                   sel_b;
  logic                   op;
  logic                   wr_acc;
  logic                   rd_ram;
  logic                   wr_ram;
  logic                   halted;
  logic                   illegal;

  modport master (
    input  start, instr,
    output prog_addr, data_addr, signal_ext, sel_a, sel_b, op,
           wr_acc, rd_ram, wr_ram, halted, illegal
  );

  modport slave (
    output start, instr,
    input  prog_addr, data_addr, signal_ext, sel_a, sel_b, op,
           wr_acc, rd_ram, wr_ram, halted, illegal
  );

endinterface

// File: rtl/bip_decoder.sv
// Combinational opcode -> control word decode for the BIP datapath.
// Unknown opcodes produce no enables and flag is_illegal.
module bip_decoder
  import bip_pkg::*;
(
  input  logic [OPCODE_LENGTH-1:0] i_opcode,
  output ctrl_t                    o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_opcode)
      OP_HLT:  o_ctrl.is_hlt = 1'b1;
      OP_STO:  o_ctrl.wr_ram = 1'b1;
      OP_LD: begin
        o_ctrl.sel_a  = SELA_MEM;
        o_ctrl.rd_ram = 1'b1;
        o_ctrl.wr_acc = 1'b1;
      end
      OP_LDI: begin
        o_ctrl.sel_a  = SELA_SIG;
        o_ctrl.wr_acc = 1'b1;
      end
      OP_ADD, OP_SUB: begin
        o_ctrl.sel_a  = SELA_ALU;
        o_ctrl.sel_b  = MEMORY;
        o_ctrl.op     = (i_opcode == OP_SUB);
        o_ctrl.rd_ram = 1'b1;
        o_ctrl.wr_acc = 1'b1;
      end
      OP_ADDI, OP_SUBI: begin
        o_ctrl.sel_a  = SELA_ALU;
        o_ctrl.sel_b  = SIGNAL;
        o_ctrl.op     = (i_opcode == OP_SUBI);
        o_ctrl.wr_acc = 1'b1;
      end
      default: o_ctrl.is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/bip_control_unit.sv
// BIP sequencer: FETCH/EXEC loop over synchronous program memory, gating decoded
// controls to EXEC. Define BIP_CTRL_ILLEGAL_EN to halt on illegal opcodes.
module bip_control_unit
  import bip_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  bip_control_unit_if.master bus
);

`ifdef BIP_CTRL_ILLEGAL_EN
  localparam bit ILLEGAL_HALT = 1'b1;
`else
  localparam bit ILLEGAL_HALT = 1'b0;
`endif

  state_t                 r_state;
  logic [ADDR_LENGTH-1:0] r_pc;
  logic                   r_illegal;
  ctrl_t                  w_ctrl;
  logic                   w_exec;
  logic                   w_stop;

  bip_decoder u_decoder (
    .i_opcode (bus.instr[DATA_LENGTH-1:ADDR_LENGTH]),
    .o_ctrl   (w_ctrl)
  );

  assign w_exec = (r_state == ST_EXEC);
  assign w_stop = w_ctrl.is_hlt || (ILLEGAL_HALT && w_ctrl.is_illegal);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_pc      <= '0;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_pc <= '0;
          if (bus.start) r_state <= ST_FETCH;
        end
        ST_FETCH: r_state <= ST_EXEC;
        ST_EXEC: begin
          if (w_stop) begin
            r_state <= ST_HALT;
            if (ILLEGAL_HALT && w_ctrl.is_illegal) r_illegal <= 1'b1;
          end else begin
            r_pc    <= r_pc + 1'b1;
            r_state <= ST_FETCH;
          end
        end
        default: r_state <= ST_HALT;
      endcase
    end
  end

  // Controls are live only in EXEC; an async reset drops them before any commit edge.
  assign bus.prog_addr  = r_pc;
  assign bus.data_addr  = w_exec ? bus.instr[ADDR_LENGTH-1:0] : '0;
  assign bus.signal_ext = w_exec ? {{(DATA_LENGTH-ADDR_LENGTH){bus.instr[ADDR_LENGTH-1]}},
                                    bus.instr[ADDR_LENGTH-1:0]} : '0;
  assign bus.sel_a      = w_exec ? w_ctrl.sel_a : SELA_MEM;
  assign bus.sel_b      = w_exec ? w_ctrl.sel_b : MEMORY;
  assign bus.op         = w_exec & w_ctrl.op;
  assign bus.wr_acc     = w_exec & w_ctrl.wr_acc;
  assign bus.rd_ram     = w_exec & w_ctrl.rd_ram;
  assign bus.wr_ram     = w_exec & w_ctrl.wr_ram;
  assign bus.halted     = (r_state == ST_HALT);
  assign bus.illegal    = r_illegal;

endmodule

// File: tb/tb_bip_control_unit.sv
// Directed bench for bip_control_unit with a synchronous program-memory model.
module tb_bip_control_unit;

  logic        clk;
  logic        rst_n;
  logic [15:0] mem [0:2047];
  int          n_vec;
  int          n_err;

  bip_control_unit_if bus ();

  bip_control_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program memory: read data valid one cycle after the address.
  always @(posedge clk) bus.instr <= mem[bus.prog_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Leaves the bench at the negedge of the first FETCH.
  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic fill(input logic [15:0] word);
    for (int i = 0; i < 2048; i++) mem[i] = word;
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    fill(16'h1800);
    mem[0] = 16'h1805;
    mem[1] = 16'h2FFF;
    mem[2] = 16'h3010;
    mem[3] = 16'h0000;

    @(negedge clk);
    @(negedge clk);
    chk("rst_prog_addr", 32'(bus.prog_addr), 32'h0);
    chk("rst_halted",    32'(bus.halted),    32'h0);
    chk("rst_illegal",   32'(bus.illegal),   32'h0);
    chk("rst_enables",   32'({bus.wr_acc, bus.rd_ram, bus.wr_ram}), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_prog_addr", 32'(bus.prog_addr), 32'h0);

    pulse_start();
    chk("fetch0_wr_acc", 32'(bus.wr_acc), 32'h0);
    @(negedge clk);
    chk("ldi_sel_a",      32'(bus.sel_a),      32'h1);
    chk("ldi_wr_acc",     32'(bus.wr_acc),     32'h1);
    chk("ldi_signal_ext", 32'(bus.signal_ext), 32'h0005);
    chk("ldi_prog_addr",  32'(bus.prog_addr),  32'h0);
    @(negedge clk);
    chk("fetch1_prog_addr", 32'(bus.prog_addr), 32'h1);
    chk("fetch1_outs", 32'({bus.sel_a, bus.wr_acc, bus.signal_ext}), 32'h0);
    @(negedge clk);
    chk("addi_signal_ext", 32'(bus.signal_ext), 32'hFFFF);
    chk("addi_ctrl", 32'({bus.sel_a, bus.sel_b, bus.op, bus.wr_acc, bus.rd_ram, bus.wr_ram}), 32'b10_1_0_1_0_0);
    @(negedge clk);
    @(negedge clk);
    chk("sub_data_addr", 32'(bus.data_addr), 32'h010);
    chk("sub_ctrl", 32'({bus.sel_a, bus.sel_b, bus.op, bus.wr_acc, bus.rd_ram, bus.wr_ram}), 32'b10_0_1_1_1_0);
    @(negedge clk);
    chk("fetch3_prog_addr", 32'(bus.prog_addr), 32'h3);
    @(negedge clk);
    chk("hlt_exec_halted", 32'(bus.halted), 32'h0);
    chk("hlt_exec_enables", 32'({bus.wr_acc, bus.rd_ram, bus.wr_ram}), 32'h0);
    @(negedge clk);
    chk("hlt_halted",    32'(bus.halted),    32'h1);
    chk("hlt_prog_addr", 32'(bus.prog_addr), 32'h3);
    pulse_start();
    @(negedge clk);
    chk("hlt_start_halted",    32'(bus.halted),    32'h1);
    chk("hlt_start_prog_addr", 32'(bus.prog_addr), 32'h3);

    // STO, then async reset in the middle of its EXEC.
    mem[0] = 16'h0820;
    do_reset();
    pulse_start();
    @(negedge clk);
    chk("sto_wr_ram",    32'(bus.wr_ram),    32'h1);
    chk("sto_data_addr", 32'(bus.data_addr), 32'h020);
    chk("sto_others", 32'({bus.wr_acc, bus.rd_ram, bus.sel_a, bus.sel_b, bus.op}), 32'h0);
    #1 rst_n = 1'b0;
    #1 chk("rst_mid_wr_ram", 32'(bus.wr_ram), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("post_rst_prog_addr", 32'(bus.prog_addr), 32'h0);
    chk("post_rst_halted",    32'(bus.halted),    32'h0);
    chk("post_rst_wr_ram",    32'(bus.wr_ram),    32'h0);

    // Illegal opcode 0x1F.
    mem[0] = 16'hF800;
    mem[1] = 16'h1805;
    do_reset();
    pulse_start();
    @(negedge clk);
    chk("ill_enables", 32'({bus.wr_acc, bus.rd_ram, bus.wr_ram}), 32'h0);
    @(negedge clk);
`ifdef BIP_CTRL_ILLEGAL_EN
    chk("ill_flag",      32'(bus.illegal),   32'h1);
    chk("ill_halted",    32'(bus.halted),    32'h1);
    chk("ill_prog_addr", 32'(bus.prog_addr), 32'h0);
`else
    chk("ill_flag",      32'(bus.illegal),   32'h0);
    chk("ill_halted",    32'(bus.halted),    32'h0);
    chk("ill_prog_addr", 32'(bus.prog_addr), 32'h1);
    @(negedge clk);
    chk("ill_next_wr_acc", 32'(bus.wr_acc), 32'h1);
`endif

    // PC wrap over a stream of LDI 0.
    fill(16'h1800);
    do_reset();
    pulse_start();
    repeat (2 * 2047) @(negedge clk);
    chk("wrap_fetch_2047", 32'(bus.prog_addr), 32'd2047);
    @(negedge clk);
    chk("wrap_exec_wr_acc", 32'(bus.wr_acc), 32'h1);
    @(negedge clk);
    chk("wrap_prog_addr_0", 32'(bus.prog_addr), 32'h0);
    chk("wrap_halted",      32'(bus.halted),    32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
